// File: rtl/patbuf_pkg.sv
// patbuf_pkg: shared pattern-buffer geometry defaults, loader state encoding and counter widths
package patbuf_pkg;
  localparam int PB_WIDTH = 8;
  localparam int PB_SIZE = 32;
  localparam int PB_BIT_CW = $clog2(PB_WIDTH);
  localparam int PB_BYTE_CW = $clog2(PB_SIZE);
  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;
endpackage

// File: rtl/pattern_rx_shift.sv
// pattern_rx_shift: deserialises sout during a shift into readback bytes, MSB first
module pattern_rx_shift
  import patbuf_pkg::*;
#(
  parameter int WIDTH = PB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] nxt;
  logic [CW-1:0] cnt;
  logic full;
  assign nxt = {cap[WIDTH-2:0], din};
  assign full = cnt == CW'(WIDTH - 1);
  // capture one bit per shift cycle; publish the byte the cycle after its last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      cap <= '0;
      cnt <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= en && full;
      if (clr) cnt <= '0;
      else if (en) begin
        cap <= nxt;
        cnt <= full ? '0 : cnt + CW'(1);
        if (full) rd_data <= nxt;
      end
    end
  end
endmodule

// File: rtl/pattern_loader.sv
// pattern_loader: streams a frame of bytes into the pattern buffer scan chain; readback under PATTERN_LOADER_READBACK_EN
module pattern_loader
  import patbuf_pkg::*;
#(
  parameter int BUFFER_WIDTH = PB_WIDTH,
  parameter int BUFFER_SIZE = PB_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [BUFFER_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    ssel,
  output logic                    sin,
  input  logic                    sout,
  output logic [BUFFER_WIDTH-1:0] rd_data,
  output logic                    rd_valid
);
  localparam int BTW = $clog2(BUFFER_WIDTH);
  localparam int BYW = $clog2(BUFFER_SIZE);
  state_t state, next;
  logic [BTW-1:0] bit_cnt;
  logic [BYW-1:0] byte_cnt;
  logic [BUFFER_WIDTH-1:0] sreg;
  logic xfer, last_bit, last_byte;
  assign sin = sreg[BUFFER_WIDTH-1];
  // next state and handshake; a byte boundary inside SHIFT offers ready for one cycle to stream gaplessly
  always_comb begin
    last_bit = bit_cnt == '0;
    last_byte = byte_cnt == BYW'(BUFFER_SIZE - 1);
    in_ready = state == WAIT || (state == SHIFT && last_bit && !last_byte);
    xfer = in_valid && in_ready;
    busy = state == WAIT || state == SHIFT;
    done = state == DONE;
    next = state == IDLE  ? (start ? WAIT : IDLE) :
           state == WAIT  ? (xfer ? SHIFT : WAIT) :
           state == SHIFT ? (!last_bit ? SHIFT : last_byte ? DONE : xfer ? SHIFT : WAIT) :
                            IDLE;
  end
  // state register, shift datapath and frame counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ssel <= 1'b0;
      sreg <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      state <= next;
      ssel <= next == SHIFT;
      if (state == IDLE && start) byte_cnt <= '0;
      if (state == SHIFT && last_bit && !last_byte) byte_cnt <= byte_cnt + BYW'(1);
      if (xfer) begin
        sreg <= in_data;
        bit_cnt <= BTW'(BUFFER_WIDTH - 1);
      end else if (state == SHIFT) begin
        sreg <= sreg << 1;
        bit_cnt <= bit_cnt - BTW'(1);
      end
    end
  end
`ifdef PATTERN_LOADER_READBACK_EN
  pattern_rx_shift #(.WIDTH(BUFFER_WIDTH)) u_rx (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE && start),
    .en(ssel),
    .din(sout),
    .rd_data(rd_data),
    .rd_valid(rd_valid)
  );
`else
  logic unused_sout;
  assign unused_sout = sout;
  assign rd_data = '0;
  assign rd_valid = 1'b0;
`endif
endmodule

// File: tb/tb_pattern_loader.sv
// tb_pattern_loader: frame table plus random data against a scan-chain buffer model and frame-level expectations
module tb_pattern_loader;
  localparam int W = 8;
  localparam int N = 32;
  localparam int BITS = W * N;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, sout;
  logic [W-1:0] in_data = '0;
  logic busy, done, in_ready, ssel, sin, rd_valid;
  logic [W-1:0] rd_data;
  logic pre = 0;
  logic [BITS-1:0] pre_val, buf_q;
  int checks = 0, errors = 0;

  typedef struct {
    int mode;
    logic [7:0] first;
    int gap_idx;
    int gap_len;
    int start_at;
    int abort_at;
    int exp_done;
    int exp_gap;
  } vec_t;
  vec_t tbl[6];

  pattern_loader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ssel(ssel), .sin(sin), .sout(sout), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // external pattern buffer: one long chain, new bits enter field 0 bit 0, sout is field N-1 bit W-1
  always @(posedge clk) begin
    if (pre) buf_q <= pre_val;
    else if (ssel) buf_q <= {buf_q[BITS-2:0], sin};
  end
  assign sout = buf_q[BITS-1];

  task automatic chk(input string n, input logic [BITS-1:0] a, input logic [BITS-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] bytes[N];
    logic [BITS-1:0] old, exp_stream, sin_vec, rd_vec;
    int k, gapleft, x0, first_ssel, last_ssel, ssel_cnt, done_cnt, done_cyc, rd_cnt, last_rd, ab;
    bit fin, rdy, give, busy1, busy_at_done;
    exp_stream = '0;
    for (int i = 0; i < N; i++) begin
      bytes[i] = v.mode == 0 ? 8'(i) : 8'($urandom_range(0, 255));
      if (v.mode != 0 && i == 0) bytes[i] = v.first;
      exp_stream = {exp_stream[BITS-9:0], bytes[i]};
    end
    old = buf_q;
    k = 0; gapleft = v.gap_idx == 0 ? v.gap_len : 0;
    x0 = -1; first_ssel = -1; last_ssel = -1; ssel_cnt = 0; done_cnt = 0; done_cyc = -1;
    rd_cnt = 0; last_rd = -1; ab = -1; fin = 0; busy1 = 0; busy_at_done = 1;
    sin_vec = '0; rd_vec = '0;
    for (int cyc = 0; cyc < 900 && !fin; cyc++) begin
      @(negedge clk);
      if (ssel) begin
        if (ssel_cnt == 0) first_ssel = cyc;
        last_ssel = cyc;
        ssel_cnt++;
        sin_vec = {sin_vec[BITS-2:0], sin};
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (rd_valid) begin
        rd_cnt++;
        last_rd = cyc;
        rd_vec = {rd_vec[BITS-9:0], rd_data};
      end
      if (cyc == 1) busy1 = busy;
      if (ab >= 0 && cyc == ab + 1) begin
        rst = 0;
        chk("abort_ssel", ssel, 1'b0);
        chk("abort_busy", busy, 1'b0);
      end
      if (ab >= 0 && cyc == ab + 20) fin = 1;
      if (v.abort_at > 0 && ab < 0 && ssel && ssel_cnt == v.abort_at) begin
        rst = 1;
        ab = cyc;
        k = 99;
      end
      start = cyc == 0 || (v.start_at > 0 && ssel && ssel_cnt == v.start_at);
      rdy = in_ready;
      give = k < N && gapleft == 0;
      if (rdy) begin
        in_valid = give;
        in_data = give ? bytes[k] : 8'($urandom_range(0, 255));
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom_range(0, 255));
      end
      if (rdy && give) begin
        if (k == 0) x0 = cyc;
        k++;
        gapleft = k == v.gap_idx ? v.gap_len : 0;
      end else if (rdy && gapleft > 0) gapleft--;
      if (done_cnt > 0 && cyc == done_cyc + 2) fin = 1;
    end
    start = 0;
    in_valid = 0;
    chk("done_count", done_cnt, v.exp_done);
    chk("busy_after_start", busy1, 1'b1);
    if (v.exp_done != 0) begin
      chk("ssel_count", ssel_cnt, BITS);
      chk("first_ssel_latency", first_ssel - x0, 1);
      chk("ssel_span", last_ssel - first_ssel + 1, BITS + v.exp_gap);
      chk("done_latency", done_cyc - x0, BITS + 1 + v.exp_gap);
      chk("busy_at_done", busy_at_done, 1'b0);
      chk("sin_stream", sin_vec, exp_stream);
      chk("field_top", buf_q[BITS-1 -: W], bytes[0]);
      chk("field_0", buf_q[W-1:0], bytes[N-1]);
      chk("buffer", buf_q, exp_stream);
`ifdef PATTERN_LOADER_READBACK_EN
      chk("rd_count", rd_cnt, N);
      chk("rd_bytes", rd_vec, old);
      chk("rd_last_with_done", last_rd, done_cyc);
`endif
    end
`ifndef PATTERN_LOADER_READBACK_EN
    chk("rd_none", rd_cnt, 0);
    chk("rd_data_zero", rd_data, 8'h00);
`endif
  endtask

  initial begin
    int hits;
    tbl[0] = '{0, 8'h00, 0, 0, 0, 0, 1, 0};
    tbl[1] = '{1, 8'hA5, 0, 0, 0, 0, 1, 0};
    tbl[2] = '{0, 8'h00, 4, 5, 0, 0, 1, 5};
    tbl[3] = '{1, 8'h3C, 0, 3, 10, 0, 1, 0};
    tbl[4] = '{1, 8'hFF, 0, 0, 0, 100, 0, 0};
    tbl[5] = '{1, 8'h81, 31, 1, 0, 0, 1, 1};
    for (int i = 0; i < N; i++) pre_val[i*W +: W] = 8'(i);
    pre = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_ssel", ssel, 1'b0);
    chk("rst_sin", sin, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_valid", rd_valid, 1'b0);
    rst = 0;
    pre = 0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      in_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      hits += int'(ssel) + int'(in_ready) + int'(busy);
    end
    in_valid = 0;
    chk("idle_without_start", hits, 0);
    for (int i = 0; i < 6; i++) run_frame(tbl[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
